// File: rtl/ov7670_capture_fb_if.sv
// Camera byte-stream inputs and frame-buffer write/status outputs of the OV7670 capture stage.
interface ov7670_capture_fb_if;
    logic        cam_pclk;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [8:0]  wr_data;
    logic        frame_done;
    logic        overflow;

    modport master (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output wr_en, wr_addr, wr_data, frame_done, overflow
    );

    modport slave (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  wr_en, wr_addr, wr_data, frame_done, overflow
    );
endinterface

// File: rtl/ov7670_capture_fb.sv
// OV7670 RGB565 byte-stream capture into a row-major RGB333 frame buffer, all in the clk27 domain.
// Define CAPTURE_COLORBAR_EN to replace camera pixels with eight vertical test bars.
module ov7670_capture_fb #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk27,
    input  logic                reset,
    ov7670_capture_fb_if.master bus
);
    localparam int COL_W = $clog2(H_ACTIVE + 1);
    localparam int ROW_W = $clog2(V_ACTIVE + 1);
    localparam logic [COL_W-1:0] COL_MAX   = COL_W'(H_ACTIVE);
    localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(V_ACTIVE);
    localparam logic [18:0]      LINE_STEP = 19'(H_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

`ifdef CAPTURE_COLORBAR_EN
    localparam int BAR_W = H_ACTIVE / 8;

    function automatic logic [8:0] bar_pixel(input logic [COL_W-1:0] col);
        logic [COL_W-1:0] bar;
        bar = col / COL_W'(BAR_W);
        return {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
    endfunction
`endif

    logic [SYNC_STAGES-1:0] pclk_sync_q;
    logic [SYNC_STAGES-1:0] vsync_sync_q;
    logic [SYNC_STAGES-1:0] href_sync_q;
    logic [7:0]             data_sync_q [SYNC_STAGES];

    // Camera inputs pass through SYNC_STAGES flops each
    always_ff @(posedge clk27) begin
        if (reset) begin
            pclk_sync_q  <= {SYNC_STAGES{1'b0}};
            vsync_sync_q <= {SYNC_STAGES{1'b0}};
            href_sync_q  <= {SYNC_STAGES{1'b0}};
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= 8'h00;
            end
        end else begin
            pclk_sync_q    <= {pclk_sync_q[SYNC_STAGES-2:0], bus.cam_pclk};
            vsync_sync_q   <= {vsync_sync_q[SYNC_STAGES-2:0], bus.cam_vsync};
            href_sync_q    <= {href_sync_q[SYNC_STAGES-2:0], bus.cam_href};
            data_sync_q[0] <= bus.cam_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= data_sync_q[i-1];
            end
        end
    end

    logic       pclk_d1_q, vsync_d1_q, href_d1_q;
    logic       pclk_rise_q, vsync_rise_q, href_fall_q;
    logic [7:0] byte_q;

    // Edge events are registered together with the levels and byte they belong to
    always_ff @(posedge clk27) begin
        if (reset) begin
            pclk_d1_q    <= 1'b0;
            vsync_d1_q   <= 1'b0;
            href_d1_q    <= 1'b0;
            pclk_rise_q  <= 1'b0;
            vsync_rise_q <= 1'b0;
            href_fall_q  <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            pclk_d1_q    <= pclk_sync_q[SYNC_STAGES-1];
            vsync_d1_q   <= vsync_sync_q[SYNC_STAGES-1];
            href_d1_q    <= href_sync_q[SYNC_STAGES-1];
            pclk_rise_q  <= pclk_sync_q[SYNC_STAGES-1] & ~pclk_d1_q;
            vsync_rise_q <= vsync_sync_q[SYNC_STAGES-1] & ~vsync_d1_q;
            href_fall_q  <= ~href_sync_q[SYNC_STAGES-1] & href_d1_q;
            byte_q       <= data_sync_q[SYNC_STAGES-1];
        end
    end

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [18:0]      row_base_q, row_base_d;
    logic             phase_q, phase_d;
    logic [5:0]       hi_q, hi_d;
    logic             pix_vld_q, pix_vld_d;
    logic [18:0]      pix_addr_q, pix_addr_d;
    logic [8:0]       pix_data_q, pix_data_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    // Capture FSM state and pixel pipeline registers
    always_ff @(posedge clk27) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            col_q      <= {COL_W{1'b0}};
            row_q      <= {ROW_W{1'b0}};
            row_base_q <= 19'd0;
            phase_q    <= 1'b0;
            hi_q       <= 6'd0;
            pix_vld_q  <= 1'b0;
            pix_addr_q <= 19'd0;
            pix_data_q <= 9'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            phase_q    <= phase_d;
            hi_q       <= hi_d;
            pix_vld_q  <= pix_vld_d;
            pix_addr_q <= pix_addr_d;
            pix_data_q <= pix_data_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next state, line/column bookkeeping and pixel assembly
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        phase_d    = phase_q;
        hi_d       = hi_q;
        pix_vld_d  = 1'b0;
        pix_addr_d = pix_addr_q;
        pix_data_d = pix_data_q;
        done_d     = 1'b0;
        ovf_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (vsync_rise_q) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                col_d      = {COL_W{1'b0}};
                row_d      = {ROW_W{1'b0}};
                row_base_d = 19'd0;
                phase_d    = 1'b0;
                if (!vsync_d1_q) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_ACTIVE: begin
                if (vsync_rise_q) begin
                    done_d  = 1'b1;
                    state_d = ST_ARMED;
                end else if (href_fall_q) begin
                    // A pending odd byte is dropped; row and row_base stop at the frame end
                    phase_d = 1'b0;
                    col_d   = {COL_W{1'b0}};
                    if (row_q < ROW_MAX) begin
                        row_d      = row_q + ROW_W'(1);
                        row_base_d = row_base_q + LINE_STEP;
                    end else begin
                        row_d      = row_q;
                        row_base_d = row_base_q;
                    end
                end else if (pclk_rise_q && href_d1_q) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hi_d = {byte_q[7:5], byte_q[2:0]};
                    end else if ((col_q < COL_MAX) && (row_q < ROW_MAX)) begin
                        pix_vld_d  = 1'b1;
                        pix_addr_d = row_base_q + 19'(col_q);
`ifdef CAPTURE_COLORBAR_EN
                        pix_data_d = bar_pixel(col_q);
`else
                        pix_data_d = {hi_q, byte_q[4:2]};
`endif
                        col_d      = col_q + COL_W'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    logic        wr_en_q;
    logic [18:0] wr_addr_q;
    logic [8:0]  wr_data_q;
    logic        frame_done_q;
    logic        overflow_q;

    // Output registers; address and data hold between writes
    always_ff @(posedge clk27) begin
        if (reset) begin
            wr_en_q      <= 1'b0;
            wr_addr_q    <= 19'd0;
            wr_data_q    <= 9'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_en_q      <= pix_vld_q;
            frame_done_q <= done_q;
            overflow_q   <= overflow_q | ovf_q;
            if (pix_vld_q) begin
                wr_addr_q <= pix_addr_q;
                wr_data_q <= pix_data_q;
            end else begin
                wr_addr_q <= wr_addr_q;
                wr_data_q <= wr_data_q;
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_done = frame_done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ov7670_capture_fb.sv
// Directed/random bench for ov7670_capture_fb with a line-level reference model and write scoreboard.
`timescale 1ns/1ps
module tb_ov7670_capture_fb;
    localparam int H = 640;
    localparam int V = 4;
    localparam int S = 2;

    logic clk27 = 1'b0;
    logic reset;

    ov7670_capture_fb_if bus ();

    ov7670_capture_fb #(.H_ACTIVE(H), .V_ACTIVE(V), .SYNC_STAGES(S)) dut (
        .clk27 (clk27),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk27 = ~clk27;

    int vectors     = 0;
    int miscompares = 0;
    int seen_done   = 0;
    int exp_done    = 0;
    int n_writes    = 0;
    int writes_before;

    logic [18:0] exp_addr_q [$];
    logic [8:0]  exp_data_q [$];
    logic [7:0]  line_q [$];

    bit          m_capturing;
    int          m_line;
    logic        exp_ovf;
    logic [18:0] last_addr;
    logic [8:0]  last_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef CAPTURE_COLORBAR_EN
    function automatic logic [8:0] ref_pixel(input int col);
        int bar;
        bar = col / (H / 8);
        return {{3{bar[2]}}, {3{bar[1]}}, {3{bar[0]}}};
    endfunction
`else
    function automatic logic [8:0] ref_pixel(input logic [7:0] b0, input logic [7:0] b1);
        logic [15:0] w;
        int r, g, b;
        w = {b0, b1};
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        return 9'(((r / 4) * 64) + ((g / 8) * 8) + (b / 4));
    endfunction
`endif

    // Expected writes for the line held in line_q at the current model row
    task automatic model_line();
        int npix;
        logic [8:0] d;
        npix = line_q.size() / 2;
        if (m_capturing) begin
            for (int k = 0; k < npix; k++) begin
                if (k < H && m_line < V) begin
`ifdef CAPTURE_COLORBAR_EN
                    d = ref_pixel(k);
`else
                    d = ref_pixel(line_q[2*k], line_q[2*k+1]);
`endif
                    last_addr = 19'(m_line * H + k);
                    last_data = d;
                    exp_addr_q.push_back(last_addr);
                    exp_data_q.push_back(d);
                end else begin
                    exp_ovf = 1'b1;
                end
            end
            m_line++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic href_at_rise);
        @(negedge clk27);
        bus.cam_data = b;
        bus.cam_pclk = 1'b0;
        @(negedge clk27);
        @(negedge clk27);
        bus.cam_pclk = 1'b1;
        bus.cam_href = href_at_rise;
        @(negedge clk27);
    endtask

    task automatic send_line(input bit collide);
        model_line();
        @(negedge clk27);
        bus.cam_href = 1'b1;
        foreach (line_q[i]) send_byte(line_q[i], 1'b1);
        if (collide) begin
            send_byte(8'($urandom), 1'b0);
        end else begin
            @(negedge clk27);
            bus.cam_href = 1'b0;
        end
        tick(4);
    endtask

    task automatic fill_random(input int n);
        line_q.delete();
        for (int i = 0; i < n; i++) line_q.push_back(8'($urandom));
    endtask

    task automatic vsync_pulse();
        if (m_capturing) exp_done++;
        m_capturing = 1'b1;
        m_line      = 0;
        @(negedge clk27);
        bus.cam_vsync = 1'b1;
        tick(6);
        bus.cam_vsync = 1'b0;
        tick(6);
    endtask

    task automatic model_reset();
        m_capturing = 1'b0;
        m_line      = 0;
        exp_ovf     = 1'b0;
        last_addr   = 19'd0;
        last_data   = 9'd0;
    endtask

    task automatic check_outputs_reset(input string phase);
        check({phase, "_wr_en"},      32'(bus.wr_en),      32'd0);
        check({phase, "_wr_addr"},    32'(bus.wr_addr),    32'd0);
        check({phase, "_wr_data"},    32'(bus.wr_data),    32'd0);
        check({phase, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        check({phase, "_overflow"},   32'(bus.overflow),   32'd0);
    endtask

    // Scoreboard: each write strobe must match the next expected address/data
    always @(negedge clk27) begin
        if (bus.frame_done === 1'b1) seen_done++;
        if (bus.wr_en === 1'b1) begin
            n_writes++;
            check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
            if (exp_addr_q.size() != 0) begin
                check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr_q.pop_front()));
                check("wr_data", 32'(bus.wr_data), 32'(exp_data_q.pop_front()));
            end
        end
    end

    initial begin
        reset         = 1'b1;
        bus.cam_pclk  = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        model_reset();
        tick(4);
        check_outputs_reset("reset");
        reset = 1'b0;
        tick(4);

        // Pixels before any vsync must not be written
        fill_random(8);
        send_line(1'b0);
        check("pre_vsync_writes", 32'(n_writes), 32'd0);

        // Full frame of 8'hF8,8'h00 pixels
        vsync_pulse();
        check("arm_no_done", 32'(seen_done), 32'd0);
        for (int r = 0; r < V; r++) begin
            line_q.delete();
            for (int c = 0; c < H; c++) begin
                line_q.push_back(8'hF8);
                line_q.push_back(8'h00);
            end
            send_line(1'b0);
        end
        tick(10);
        check("frame1_pending", 32'(exp_addr_q.size()), 32'd0);
        check("frame1_writes", 32'(n_writes), 32'(H * V));
        check("frame1_last_addr", 32'(bus.wr_addr), 32'(H * V - 1));
`ifndef CAPTURE_COLORBAR_EN
        check("frame1_data", 32'(bus.wr_data), 32'h1C0);
`endif
        check("frame1_overflow", 32'(bus.overflow), 32'd0);
        vsync_pulse();
        check("frame1_done", 32'(seen_done), 32'(exp_done));

        // Second frame: short line, overlong line, directed line, collision line, out-of-frame line
        fill_random(6);
        send_line(1'b0);
        check("short_line_overflow", 32'(bus.overflow), 32'd0);
        fill_random(2 * H + 3);
        send_line(1'b0);
        check("long_line_overflow", 32'(bus.overflow), 32'(exp_ovf));
        line_q = {8'h07, 8'hE0, 8'h00, 8'h1F};
        send_line(1'b0);
        check("row2_last_addr", 32'(bus.wr_addr), 32'd1281);
        check("row2_last_data", 32'(bus.wr_data), 32'(last_data));
        fill_random(9);
        send_line(1'b1);
        fill_random(2);
        send_line(1'b0);
        tick(10);
        check("frame2_pending", 32'(exp_addr_q.size()), 32'd0);
        check("frame2_overflow", 32'(bus.overflow), 32'd1);
        vsync_pulse();
        check("frame2_done", 32'(seen_done), 32'(exp_done));

        // Write latency from the second byte's pclk high
        fill_random(2);
        model_line();
        @(negedge clk27);
        bus.cam_href = 1'b1;
        send_byte(line_q[0], 1'b1);
        @(negedge clk27);
        bus.cam_data = line_q[1];
        bus.cam_pclk = 1'b0;
        @(negedge clk27);
        @(negedge clk27);
        bus.cam_pclk = 1'b1;
        repeat (S + 2) @(posedge clk27);
        #1 check("wr_en_before_latency", 32'(bus.wr_en), 32'd0);
        @(posedge clk27);
        #1 check("wr_en_at_latency", 32'(bus.wr_en), 32'd1);
        @(posedge clk27);
        #1 check("wr_en_one_cycle", 32'(bus.wr_en), 32'd0);
        @(negedge clk27);
        bus.cam_href = 1'b0;
        tick(4);

        // frame_done latency from vsync high
        exp_done++;
        m_line = 0;
        @(negedge clk27);
        bus.cam_vsync = 1'b1;
        repeat (S + 2) @(posedge clk27);
        #1 check("done_before_latency", 32'(bus.frame_done), 32'd0);
        @(posedge clk27);
        #1 check("done_at_latency", 32'(bus.frame_done), 32'd1);
        @(posedge clk27);
        #1 check("done_one_cycle", 32'(bus.frame_done), 32'd0);
        @(negedge clk27);
        bus.cam_vsync = 1'b0;
        tick(6);

        // Reset in the middle of a line
        fill_random(2);
        model_line();
        @(negedge clk27);
        bus.cam_href = 1'b1;
        send_byte(line_q[0], 1'b1);
        send_byte(line_q[1], 1'b1);
        send_byte(8'($urandom), 1'b1);
        tick(8);
        check("pre_reset_pending", 32'(exp_addr_q.size()), 32'd0);
        @(negedge clk27);
        reset = 1'b1;
        @(negedge clk27);
        check_outputs_reset("midline_reset");
        tick(2);
        reset = 1'b0;
        model_reset();
        writes_before = n_writes;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
        @(negedge clk27);
        bus.cam_href = 1'b0;
        tick(4);
        fill_random(6);
        send_line(1'b0);
        check("no_write_after_reset", 32'(n_writes - writes_before), 32'd0);

        vsync_pulse();
        fill_random(8);
        send_line(1'b0);
        tick(10);
        check("restart_pending", 32'(exp_addr_q.size()), 32'd0);
        check("restart_last_addr", 32'(bus.wr_addr), 32'd3);
        check("restart_last_data", 32'(bus.wr_data), 32'(last_data));
        check("restart_overflow", 32'(bus.overflow), 32'd0);
        vsync_pulse();
        check("final_done", 32'(seen_done), 32'(exp_done));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
